mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Sits directly downstream of the CPU datapath. Services its MAR/MDR memory requests (opcode fetch, data read, data write) and drives the external 16-bit-address / 8-bit-data GameBoy memory bus.
- Enforces a minimum M-cycle length and handles slave wait states with a timeout.
- Serves high RAM (0xFF80–0xFFFE) internally in one cycle.
- Returns read data to the datapath (MDR, or IR for fetches) through a one-cycle response pulse.

Parameters:
- MIN_CYCLES, 4: minimum cycles an external strobe stays asserted (one M-cycle = 4 T-cycles); legal range 1–15.
- TIMEOUT, 64: ACCESS cycles after which a stalled access is abandoned; must be greater than MIN_CYCLES; legal range up to 255.
- HRAM_EN, 1: 1 = serve 0xFF80–0xFFFE from internal 127x8 RAM; 0 = send every address to the bus.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: synchronous, active-low reset.
- req_valid, input, 1: datapath request present.
- req_write, input, 1: 1 = write, 0 = read.
- req_fetch, input, 1: read is an opcode fetch; ignored when req_write=1.
- req_addr, input, 16: access address (MAR).
- req_wdata, input, 8: write data (MDR).
- req_ready, output, 1: unit can accept a request this cycle.
- rsp_valid, output, 1: one-cycle completion pulse.
- rsp_data, output, 8: read data; for writes, the written data.
- rsp_fetch, output, 1: response belongs to an opcode fetch (datapath loads IR, not MDR).
- rsp_err, output, 1: access timed out.
- mem_addr, output, 16: bus address.
- mem_wdata, output, 8: bus write data.
- mem_rd, output, 1: bus read strobe.
- mem_wr, output, 1: bus write strobe.
- mem_rdata, input, 8: bus read data.
- mem_ready, input, 1: slave ready; 0 inserts wait states.

Behaviour:
- Reset (rst=0 at a posedge): state to IDLE.
  - req_ready=1; rsp_valid=0, rsp_data=0, rsp_fetch=0, rsp_err=0.
  - mem_addr=0, mem_wdata=0, mem_rd=0, mem_wr=0; cycle counter = 0.
  - HRAM contents not cleared.
  - Reset during any state aborts the access: strobes are 0 from the next cycle; no rsp_valid is issued.
- All outputs are registered.
- FSM states: IDLE, ACCESS, HRAM, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid=1: latch addr, wdata, write, fetch.
    - If HRAM_EN=1 and addr is in 0xFF80–0xFFFE, go to HRAM.
    - Otherwise go to ACCESS and assert mem_rd or mem_wr with mem_addr/mem_wdata; counter = 0.
  - req_ready=0 in every other state; requests are not queued.
- ACCESS:
  - Strobe, mem_addr and mem_wdata held constant; counter increments each cycle.
  - Completes on the first cycle where counter >= MIN_CYCLES-1 and mem_ready=1.
    - mem_rdata sampled that cycle.
    - Strobe deasserted next cycle; go to DONE.
  - If counter reaches TIMEOUT-1 with mem_ready=0: go to DONE with rsp_err=1 and rsp_data=0xFF (reads and writes alike).
  - mem_ready is ignored before MIN_CYCLES-1.
- HRAM: one cycle. A read registers hram[addr-0xFF80]; a write updates it. Then go to DONE. No bus strobe.
- DONE:
  - rsp_valid=1 for exactly one cycle, with rsp_data, rsp_fetch and rsp_err.
  - Return to IDLE next cycle; req_ready=1 then. No response backpressure.
  - rsp_data, rsp_fetch and rsp_err hold their values until the next DONE; rsp_err clears at the next non-error DONE.
- Latency (accept cycle = cycle 0):
  - External access, no waits: rsp_valid in cycle MIN_CYCLES+1.
  - Each wait cycle after MIN_CYCLES-1 adds 1.
  - HRAM access: rsp_valid in cycle 2.
  - Back-to-back accesses: next accept in cycle MIN_CYCLES+2 at the earliest.
- Boundaries:
  - 0xFF7F and 0xFFFF go to the bus (IE register is external).
  - mem_addr retains the last external address after completion; the strobe is the only qualifier.
  - req_fetch with req_write=1 is treated as a plain write; rsp_fetch=0.

Test Plan:
- Reset, then read 0x0150 with mem_rdata=0x3E and mem_ready=1 -> mem_rd high in cycles 1–4, rsp_valid in cycle 5, rsp_data=0x3E, rsp_fetch=(req_fetch), rsp_err=0.
- Write 0xC000←0xA5 with mem_ready low for 3 extra cycles after cycle 4 -> mem_wr high for 7 cycles, mem_wdata=0xA5 stable, rsp_valid in cycle 8, rsp_data=0xA5.
- HRAM: write 0xFF80←0x12, then read 0xFF80, then read 0xFFFE after writing 0x34 there -> reads return 0x12 and 0x34, each rsp_valid in cycle 2, mem_rd/mem_wr never asserted; read of 0xFFFF goes to the bus.
- Timeout: read 0x8000 with mem_ready held 0 -> rsp_valid in cycle 65, rsp_err=1, rsp_data=0xFF, mem_rd low afterwards; next good access clears rsp_err.
- Reset mid-access: rst=0 in cycle 2 of a write -> mem_wr=0 and req_ready=1 after that edge, no rsp_valid; a following read completes normally.
- Back-to-back: req_valid held high with two reads -> second mem_rd rises in cycle 7, req_ready low throughout ACCESS, HRAM and DONE.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - datapath memory access unit for the GameBoy bus
// Stretches external strobes to a full M-cycle, times out stalled slaves, and serves HRAM locally.
module mem_access_unit #(
   parameter int MIN_CYCLES = 4,
   parameter int TIMEOUT    = 64,
   parameter int HRAM_EN    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic        req_fetch,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_fetch,
   output logic        rsp_err,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_HRAM,
      S_DONE
   } state_t;

   localparam logic [7:0] MIN_LAST = 8'(MIN_CYCLES - 1);
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        write_q, write_d;
   logic        fetch_q, fetch_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_data_q, rsp_data_d;
   logic        rsp_fetch_q, rsp_fetch_d;
   logic        rsp_err_q, rsp_err_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;
   logic        mem_rd_q, mem_rd_d;
   logic        mem_wr_q, mem_wr_d;

   logic [7:0]  hram_q [0:126];
   logic [6:0]  hram_idx;
   logic        hram_we;
   logic        req_is_hram;

   // 0xFFFF is the IE register, which lives outside this unit.
   assign req_is_hram = (HRAM_EN != 0) && (req_addr >= 16'hFF80) && (req_addr != 16'hFFFF);
   assign hram_idx    = addr_q[6:0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      write_d     = write_q;
      fetch_d     = fetch_q;
      req_ready_d = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_fetch_d = rsp_fetch_q;
      rsp_err_d   = rsp_err_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_rd_d    = mem_rd_q;
      mem_wr_d    = mem_wr_q;
      hram_we     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid) begin
               req_ready_d = 1'b0;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               write_d     = req_write;
               fetch_d     = req_fetch & ~req_write;
               if (req_is_hram) begin
                  state_d = S_HRAM;
               end else begin
                  state_d     = S_ACCESS;
                  cnt_d       = 8'd0;
                  mem_addr_d  = req_addr;
                  mem_wdata_d = req_wdata;
                  mem_rd_d    = ~req_write;
                  mem_wr_d    = req_write;
               end
            end
         end

         S_ACCESS: begin
            cnt_d = cnt_q + 8'd1;
            // Slave ready is only honoured once the minimum strobe width is met.
            if ((cnt_q >= MIN_LAST) && mem_ready) begin
               state_d     = S_DONE;
               mem_rd_d    = 1'b0;
               mem_wr_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = write_q ? wdata_q : mem_rdata;
               rsp_fetch_d = fetch_q;
               rsp_err_d   = 1'b0;
            end else if (cnt_q == TO_LAST) begin
               state_d     = S_DONE;
               mem_rd_d    = 1'b0;
               mem_wr_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = 8'hFF;
               rsp_fetch_d = fetch_q;
               rsp_err_d   = 1'b1;
            end
         end

         S_HRAM: begin
            hram_we     = write_q;
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = write_q ? wdata_q : hram_q[hram_idx];
            rsp_fetch_d = fetch_q;
            rsp_err_d   = 1'b0;
         end

         S_DONE: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end

         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         addr_q      <= 16'h0000;
         wdata_q     <= 8'h00;
         write_q     <= 1'b0;
         fetch_q     <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         rsp_fetch_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         mem_addr_q  <= 16'h0000;
         mem_wdata_q <= 8'h00;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         write_q     <= write_d;
         fetch_q     <= fetch_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_fetch_q <= rsp_fetch_d;
         rsp_err_q   <= rsp_err_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
      end
   end

   // HRAM keeps its contents across reset; a reset in the HRAM state drops the write.
   always_ff @(posedge clk) begin
      if (rst && hram_we) begin
         hram_q[hram_idx] <= wdata_q;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_fetch = rsp_fetch_q;
   assign rsp_err   = rsp_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;

endmodule
